// File: rtl/sgd_logreg_trainer.sv
`default_nettype none
// ============================================================================
// sgd_logreg_trainer : online-SGD single-neuron logistic regression trainer
//                      with ROM-streamed features and hard-sigmoid activation
// Revision 1.0
// ============================================================================
module sgd_logreg_trainer #(
    parameter int N_FEAT   = 784,
    parameter int N_SAMP   = 40,
    parameter int EPOCHS   = 1,
    parameter int XW       = 8,
    parameter int WW       = 16,
    parameter int ACCW     = 32,
    parameter int LR_SHIFT = 0,
    parameter int AW       = 15,
    localparam int FIW     = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
    localparam int SIW     = (N_SAMP > 1) ? $clog2(N_SAMP) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           x_en,
    output logic [AW-1:0]  x_addr,
    input  logic [XW-1:0]  x_data,
    output logic [SIW-1:0] y_idx,
    input  logic           y_label,
    input  logic           w_we,
    input  logic [FIW-1:0] w_waddr,
    input  logic [WW-1:0]  w_wdata,
    input  logic [FIW-1:0] w_raddr,
    output logic [WW-1:0]  w_rdata,
    output logic           busy,
    output logic           done,
    output logic [8:0]     yhat,
    output logic           yhat_valid
);

    localparam int KW = $clog2(N_FEAT + 1);
    localparam int EW = $clog2(EPOCHS + 1);
    localparam int SW = WW + XW + 12;
    localparam logic signed [SW-1:0] WMAX = {{(SW-WW+1){1'b0}}, {(WW-1){1'b1}}};
    localparam logic signed [SW-1:0] WMIN = {{(SW-WW+1){1'b1}}, {(WW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FWD  = 3'd1,
        S_ACT  = 3'd2,
        S_UPD  = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [SIW-1:0]          sample_q, sample_d;
    logic [EW-1:0]           epoch_q, epoch_d;
    logic [AW-1:0]           base_q, base_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic signed [9:0]       err_q, err_d;
    logic [8:0]              yhat_q, yhat_d;
    logic                    yhat_valid_q, yhat_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    x_en_q, x_en_d;
    logic [AW-1:0]           x_addr_q, x_addr_d;
    logic signed [WW-1:0]    weight_q [N_FEAT];

    logic                    w_wr_en;
    logic [FIW-1:0]          w_wr_idx;
    logic [WW-1:0]           w_wr_val;

    // Feature data for step k belongs to the address issued at step k-1.
    logic [FIW-1:0]          widx;
    logic signed [WW-1:0]    w_cur;
    logic signed [XW:0]      x_s;
    logic signed [XW+WW:0]   prod_fwd;
    logic signed [ACCW-1:0]  acc_term;
    logic signed [XW+10:0]   prod_upd;
    logic signed [XW+10:0]   delta;
    logic signed [SW-1:0]    w_sum;
    logic signed [WW-1:0]    w_sat;
    logic signed [ACCW-1:0]  z_sh;
    logic [8:0]              yhat_act;
    logic signed [9:0]       err_act;

    assign widx     = FIW'(k_q - KW'(1));
    assign w_cur    = weight_q[widx];
    assign x_s      = {1'b0, x_data};
    assign prod_fwd = x_s * w_cur;
    assign acc_term = ACCW'(prod_fwd);
    assign prod_upd = x_s * err_q;
    assign delta    = prod_upd >>> (8 + LR_SHIFT);
    assign w_sum    = SW'(w_cur) - SW'(delta);
    assign w_sat    = (w_sum > WMAX) ? WMAX[WW-1:0] :
                      (w_sum < WMIN) ? WMIN[WW-1:0] : w_sum[WW-1:0];

    // Hard sigmoid: 0.5 + z/4, z in Q.16, output clamped to [0, 1.0] in Q0.8.
    assign z_sh     = (acc_q >>> 10) + ACCW'(128);
    assign yhat_act = (z_sh < 0) ? 9'd0 : (z_sh > 256) ? 9'd256 : z_sh[8:0];
    assign err_act  = $signed({1'b0, yhat_act}) - (y_label ? 10'sd256 : 10'sd0);

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        sample_d     = sample_q;
        epoch_d      = epoch_q;
        base_d       = base_q;
        acc_d        = acc_q;
        err_d        = err_q;
        yhat_d       = yhat_q;
        yhat_valid_d = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_idx     = widx;
        w_wr_val     = w_sat;
        case (state_q)
            S_IDLE: begin
                if (w_we) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = w_waddr;
                    w_wr_val = w_wdata;
                end
                if (start) begin
                    state_d  = S_FWD;
                    k_d      = '0;
                    sample_d = '0;
                    epoch_d  = '0;
                    base_d   = '0;
                end
            end
            S_FWD: begin
                if (k_q == KW'(1))
                    acc_d = acc_term;
                else if (k_q != '0)
                    acc_d = acc_q + acc_term;
                if (k_q == KW'(N_FEAT)) begin
                    state_d = S_ACT;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_ACT: begin
                yhat_d       = yhat_act;
                err_d        = err_act;
                yhat_valid_d = 1'b1;
                state_d      = S_UPD;
                k_d          = '0;
            end
            S_UPD: begin
                if (k_q != '0)
                    w_wr_en = 1'b1;
                if (k_q == KW'(N_FEAT)) begin
                    state_d = S_NEXT;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_NEXT: begin
                if (sample_q == SIW'(N_SAMP - 1)) begin
                    sample_d = '0;
                    base_d   = '0;
                    epoch_d  = epoch_q + EW'(1);
                    state_d  = (epoch_q == EW'(EPOCHS - 1)) ? S_DONE : S_FWD;
                end else begin
                    sample_d = sample_q + SIW'(1);
                    base_d   = base_q + AW'(N_FEAT);
                    state_d  = S_FWD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d   = (state_d == S_DONE);
        x_en_d   = ((state_d == S_FWD) || (state_d == S_UPD)) && (k_d < KW'(N_FEAT));
        x_addr_d = x_en_d ? (base_d + AW'(k_d)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            sample_q     <= '0;
            epoch_q      <= '0;
            base_q       <= '0;
            acc_q        <= '0;
            err_q        <= '0;
            yhat_q       <= '0;
            yhat_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            x_en_q       <= 1'b0;
            x_addr_q     <= '0;
            for (int i = 0; i < N_FEAT; i++)
                weight_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            sample_q     <= sample_d;
            epoch_q      <= epoch_d;
            base_q       <= base_d;
            acc_q        <= acc_d;
            err_q        <= err_d;
            yhat_q       <= yhat_d;
            yhat_valid_q <= yhat_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            x_en_q       <= x_en_d;
            x_addr_q     <= x_addr_d;
            if (w_wr_en)
                weight_q[w_wr_idx] <= w_wr_val;
        end
    end

    assign x_en       = x_en_q;
    assign x_addr     = x_addr_q;
    assign y_idx      = sample_q;
    assign w_rdata    = weight_q[w_raddr];
    assign busy       = busy_q;
    assign done       = done_q;
    assign yhat       = yhat_q;
    assign yhat_valid = yhat_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sgd_logreg_trainer.sv
`default_nettype none
// ============================================================================
// tb_sgd_logreg_trainer : scoreboard bench for sgd_logreg_trainer (N_FEAT=4)
// Revision 1.0
// ============================================================================
module tb_sgd_logreg_trainer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // instance a: N_SAMP=1 EPOCHS=1; b: N_SAMP=2 EPOCHS=2; c: LR_SHIFT=2
    logic        start_a = 0, start_b = 0, start_c = 0;
    logic        x_en_a, x_en_b, x_en_c;
    logic [14:0] x_addr_a, x_addr_b, x_addr_c;
    logic [7:0]  x_data_a = 0, x_data_b = 0, x_data_c = 0;
    logic [0:0]  y_idx_a, y_idx_b, y_idx_c;
    logic        y_label_a = 0, y_label_b = 0, y_label_c = 0;
    logic        w_we_a = 0, w_we_b = 0, w_we_c = 0;
    logic [1:0]  w_waddr_a = 0, w_waddr_b = 0, w_waddr_c = 0;
    logic [15:0] w_wdata_a = 0, w_wdata_b = 0, w_wdata_c = 0;
    logic [1:0]  w_raddr_a = 0, w_raddr_b = 0, w_raddr_c = 0;
    logic [15:0] w_rdata_a, w_rdata_b, w_rdata_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [8:0]  yhat_a, yhat_b, yhat_c;
    logic        yv_a, yv_b, yv_c;

    logic [7:0] rom_a [4];
    logic [7:0] rom_b [8];
    logic [7:0] rom_c [4];

    always @(posedge clk) if (x_en_a) x_data_a <= rom_a[x_addr_a[1:0]];
    always @(posedge clk) if (x_en_b) x_data_b <= rom_b[x_addr_b[2:0]];
    always @(posedge clk) if (x_en_c) x_data_c <= rom_c[x_addr_c[1:0]];

    sgd_logreg_trainer #(.N_FEAT(4), .N_SAMP(1), .EPOCHS(1), .LR_SHIFT(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .x_en(x_en_a), .x_addr(x_addr_a),
        .x_data(x_data_a), .y_idx(y_idx_a), .y_label(y_label_a), .w_we(w_we_a),
        .w_waddr(w_waddr_a), .w_wdata(w_wdata_a), .w_raddr(w_raddr_a), .w_rdata(w_rdata_a),
        .busy(busy_a), .done(done_a), .yhat(yhat_a), .yhat_valid(yv_a));

    sgd_logreg_trainer #(.N_FEAT(4), .N_SAMP(2), .EPOCHS(2), .LR_SHIFT(0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .x_en(x_en_b), .x_addr(x_addr_b),
        .x_data(x_data_b), .y_idx(y_idx_b), .y_label(y_label_b), .w_we(w_we_b),
        .w_waddr(w_waddr_b), .w_wdata(w_wdata_b), .w_raddr(w_raddr_b), .w_rdata(w_rdata_b),
        .busy(busy_b), .done(done_b), .yhat(yhat_b), .yhat_valid(yv_b));

    sgd_logreg_trainer #(.N_FEAT(4), .N_SAMP(1), .EPOCHS(1), .LR_SHIFT(2)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .x_en(x_en_c), .x_addr(x_addr_c),
        .x_data(x_data_c), .y_idx(y_idx_c), .y_label(y_label_c), .w_we(w_we_c),
        .w_waddr(w_waddr_c), .w_wdata(w_wdata_c), .w_raddr(w_raddr_c), .w_rdata(w_rdata_c),
        .busy(busy_c), .done(done_c), .yhat(yhat_c), .yhat_valid(yv_c));

    // Expected-response queues: yhat per sample, done latency, feature addresses.
    int qy_a[$], qy_b[$], qy_c[$];
    int qd_a[$], qd_b[$], qd_c[$];
    int qx_b[$];
    int sc_a = 0, sc_b = 0, sc_c = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (yv_a) begin
                if (qy_a.size() == 0) chk("yhat_a_unexpected", int'(yv_a), 0);
                else chk("yhat_a", int'(yhat_a), qy_a.pop_front());
            end
            if (yv_b) begin
                if (qy_b.size() == 0) chk("yhat_b_unexpected", int'(yv_b), 0);
                else chk("yhat_b", int'(yhat_b), qy_b.pop_front());
            end
            if (yv_c) begin
                if (qy_c.size() == 0) chk("yhat_c_unexpected", int'(yv_c), 0);
                else chk("yhat_c", int'(yhat_c), qy_c.pop_front());
            end
            if (done_a) begin
                if (qd_a.size() == 0) chk("done_a_unexpected", int'(done_a), 0);
                else chk("done_a_latency", cyc - sc_a, qd_a.pop_front());
            end
            if (done_b) begin
                if (qd_b.size() == 0) chk("done_b_unexpected", int'(done_b), 0);
                else chk("done_b_latency", cyc - sc_b, qd_b.pop_front());
            end
            if (done_c) begin
                if (qd_c.size() == 0) chk("done_c_unexpected", int'(done_c), 0);
                else chk("done_c_latency", cyc - sc_c, qd_c.pop_front());
            end
            if (x_en_b) begin
                if (qx_b.size() == 0) chk("x_en_b_unexpected", int'(x_en_b), 0);
                else chk("x_addr_b", int'(x_addr_b), qx_b.pop_front());
            end
        end
    end

    task automatic start_run(input int which);
        @(negedge clk);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        case (which)
            0: sc_a = cyc;
            1: sc_b = cyc;
            default: sc_c = cyc;
        endcase
    endtask

    task automatic load_w(input int which, input int idx, input int val);
        @(negedge clk);
        case (which)
            0: begin w_we_a = 1'b1; w_waddr_a = 2'(idx); w_wdata_a = 16'(val); end
            1: begin w_we_b = 1'b1; w_waddr_b = 2'(idx); w_wdata_b = 16'(val); end
            default: begin w_we_c = 1'b1; w_waddr_c = 2'(idx); w_wdata_c = 16'(val); end
        endcase
        @(posedge clk);
        #1;
        w_we_a = 1'b0; w_we_b = 1'b0; w_we_c = 1'b0;
    endtask

    task automatic check_w(input int which, input int idx, input int exp);
        string nm;
        nm = $sformatf("weight_%0d[%0d]", which, idx);
        case (which)
            0: begin w_raddr_a = 2'(idx); #1; chk(nm, int'($signed(w_rdata_a)), exp); end
            1: begin w_raddr_b = 2'(idx); #1; chk(nm, int'($signed(w_rdata_b)), exp); end
            default: begin w_raddr_c = 2'(idx); #1; chk(nm, int'($signed(w_rdata_c)), exp); end
        endcase
    endtask

    task automatic wait_done(input int which, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            case (which)
                0: seen = done_a;
                1: seen = done_b;
                default: seen = done_c;
            endcase
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_done_%0d: no done within %0d cycles", which, limit);
        end
    endtask

    task automatic push_b_addrs();
        for (int e = 0; e < 2; e++)
            for (int s = 0; s < 2; s++)
                for (int r = 0; r < 2; r++)
                    for (int f = 0; f < 4; f++)
                        qx_b.push_back(s * 4 + f);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 8; i++) rom_b[i] = 8'd0;
        for (int i = 0; i < 4; i++) begin rom_a[i] = 8'd255; rom_c[i] = 8'd0; end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_a_rst", int'(busy_a), 0);
        chk("done_a_rst", int'(done_a), 0);
        chk("x_en_a_rst", int'(x_en_a), 0);
        chk("yhat_a_rst", int'(yhat_a), 0);
        chk("yv_b_rst", int'(yv_b), 0);
        chk("x_addr_b_rst", int'(x_addr_b), 0);
        chk("busy_b_rst", int'(busy_b), 0);
        for (int i = 0; i < 4; i++) begin
            check_w(0, i, 0);
            check_w(1, i, 0);
        end
        rst = 1'b0;

        // A1: zero weights, x all 255, label 1 -> yhat 128, err -128, weights 128
        y_label_a = 1'b1;
        qy_a.push_back(128); qd_a.push_back(12);
        start_run(0);
        wait_done(0, 100);
        for (int i = 0; i < 4; i++) check_w(0, i, 128);

        // A2: saturating update, yhat clamped at 0
        load_w(0, 0, 32700);
        for (int i = 1; i < 4; i++) load_w(0, i, -32768);
        qy_a.push_back(0); qd_a.push_back(12);
        start_run(0);
        wait_done(0, 100);
        check_w(0, 0, 32767);
        for (int i = 1; i < 4; i++) check_w(0, i, -32513);

        // C1/C2: learning-rate shift with floor rounding
        rom_c[0] = 8'd4; y_label_c = 1'b0;
        qy_c.push_back(128); qd_c.push_back(12);
        start_run(2);
        wait_done(2, 100);
        check_w(2, 0, 0);
        rom_c[0] = 8'd255;
        qy_c.push_back(128); qd_c.push_back(12);
        start_run(2);
        wait_done(2, 100);
        check_w(2, 0, -31);
        check_w(2, 1, 0);

        // B1: address sequence, latency, start/w_we ignored while busy
        for (int i = 0; i < 4; i++) qy_b.push_back(128);
        qd_b.push_back(48);
        push_b_addrs();
        start_run(1);
        repeat (10) @(posedge clk);
        #1;
        start_b = 1'b1; w_we_b = 1'b1; w_waddr_b = 2'd0; w_wdata_b = 16'd999;
        @(posedge clk);
        #1;
        start_b = 1'b0; w_we_b = 1'b0;
        chk("busy_b_midrun", int'(busy_b), 1);
        wait_done(1, 200);
        for (int i = 0; i < 4; i++) check_w(1, i, 0);

        // B2: reset during UPD of sample 1 aborts and clears weights
        for (int i = 0; i < 4; i++) load_w(1, i, i + 5);
        check_w(1, 3, 8);
        qy_b.push_back(128); qy_b.push_back(128);
        push_b_addrs();
        start_run(1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = yv_b && (y_idx_b == 1'b1);
        end
        chk("upd_sample1_reached", int'(seen), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qx_b.delete();
        chk("busy_b_after_rst", int'(busy_b), 0);
        chk("done_b_after_rst", int'(done_b), 0);
        chk("x_en_b_after_rst", int'(x_en_b), 0);
        for (int i = 0; i < 4; i++) check_w(1, i, 0);
        repeat (60) @(posedge clk);

        // B3: normal run after abort
        for (int i = 0; i < 4; i++) qy_b.push_back(128);
        qd_b.push_back(48);
        push_b_addrs();
        start_run(1);
        wait_done(1, 200);
        for (int i = 0; i < 4; i++) check_w(1, i, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queues_drained", qy_a.size() + qy_b.size() + qy_c.size() + qd_a.size()
            + qd_b.size() + qd_c.size() + qx_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
